// File: rtl/serial_demux_deser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_demux_deser_pkg: shared lane-state type and lane constants  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package serial_demux_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } lane_state_t;

  localparam int LANE0         = 0;
  localparam int LANE1         = 1;
  localparam int DEFAULT_WIDTH = 4;

endpackage : serial_demux_deser_pkg
`default_nettype wire

// File: rtl/demux_deser_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_deser_lane: one LSB-first deserializer lane with word output |
// | Optional even-parity bit: SERIAL_DEMUX_DESER_PARITY_EN             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module demux_deser_lane
  import serial_demux_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             err
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  lane_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             valid_q, valid_d;
`ifdef SERIAL_DEMUX_DESER_PARITY_EN
  logic             err_q,   err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = 1'b0;
`ifdef SERIAL_DEMUX_DESER_PARITY_EN
    err_d   = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE, SHIFT: begin
          // Right shift: after WIDTH bits the first one sits in bit 0.
          shreg_d = {din, shreg_q[WIDTH-1:1]};
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef SERIAL_DEMUX_DESER_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            word_d  = shreg_d;
            valid_d = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SHIFT;
          end
        end
`ifdef SERIAL_DEMUX_DESER_PARITY_EN
        PAR: begin
          word_d  = shreg_q;
          valid_d = 1'b1;
          err_d   = ^{shreg_q, din};
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

`ifdef SERIAL_DEMUX_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule : demux_deser_lane
`default_nettype wire

// File: rtl/serial_demux_deser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_demux_deser: routes a serial bit stream into two lanes      |
// | Optional even-parity bit: SERIAL_DEMUX_DESER_PARITY_EN             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module serial_demux_deser
  import serial_demux_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sel,
  output logic [WIDTH-1:0] word0,
  output logic             word0_valid,
  output logic [WIDTH-1:0] word1,
  output logic             word1_valid,
  output logic             err
);

  logic w_en0;
  logic w_en1;
  logic w_err0;
  logic w_err1;

  assign w_en0 = din_valid && (sel == 1'(LANE0));
  assign w_en1 = din_valid && (sel == 1'(LANE1));

  demux_deser_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (w_en0),
    .din        (din),
    .word       (word0),
    .word_valid (word0_valid),
    .err        (w_err0)
  );

  demux_deser_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (w_en1),
    .din        (din),
    .word       (word1),
    .word_valid (word1_valid),
    .err        (w_err1)
  );

  // Only one lane accepts a bit per cycle, so at most one err is ever set.
  assign err = w_err0 | w_err1;

endmodule : serial_demux_deser
`default_nettype wire

// File: doc/serial_demux_deser.md
SERIAL_DEMUX_DESER -- requirements
Module: serial_demux_deser

Interface
- REQ-001: Parameter `WIDTH`, default 4. Number of data bits per word per lane. Legal range 2..16.
- REQ-002: `clk` input, 1 bit. Single clock; all state updates on its rising edge.
- REQ-003: `rst` input, 1 bit. Reset is synchronous and active-high.
- REQ-004: `din` input, 1 bit. Serial data bit.
- REQ-005: `din_valid` input, 1 bit. `din` is sampled only when this is 1.
- REQ-006: `sel` input, 1 bit. Lane routing: 0 routes to lane 0, 1 routes to lane 1.
- REQ-007: `word0` output, WIDTH bits. Last completed lane-0 word.
- REQ-008: `word0_valid` output, 1 bit. One-cycle pulse when `word0` updates.
- REQ-009: `word1` output, WIDTH bits. Last completed lane-1 word.
- REQ-010: `word1_valid` output, 1 bit. One-cycle pulse when `word1` updates.
- REQ-011: `err` output, 1 bit. One-cycle parity-error pulse; see Configuration.

Function
- REQ-012: Each rising edge with `din_valid`=1 SHALL shift `din` into the lane selected by `sel` only.
  - The unselected lane holds its partial state.
- REQ-013: Bits SHALL be assembled LSB-first: the first accepted bit lands in bit 0.
- REQ-014: Each lane SHALL be an FSM with states IDLE, SHIFT and PAR (PAR exists only with PARITY_EN).
  - IDLE→SHIFT on the first accepted bit.
  - SHIFT→IDLE after bit WIDTH-1, or SHIFT→PAR when parity is enabled.
  - PAR→IDLE on the accepted parity bit.
- REQ-015: Each lane SHALL keep a bit counter that counts 0..WIDTH-1 and wraps to 0 on word completion, with no skipped or extra cycle.
- REQ-016: On the edge accepting a lane's final bit, that lane SHALL update its `wordN` register, and `wordN_valid` SHALL be 1 for exactly the following cycle.
  - Latency is one cycle from the final-bit edge to the valid output.
- REQ-017: Completed words SHALL hold until that lane's next completion.
- REQ-018: `din_valid`=0 cycles SHALL change no state and SHALL not reset partial words.
- REQ-019: `sel` may toggle on any cycle.
  - Interleaved bits SHALL build both lanes independently and correctly.
  - Back-to-back completions on alternate lanes SHALL produce their respective valid pulses in consecutive cycles.
- REQ-020: `word0_valid` and `word1_valid` SHALL never be 1 in the same cycle, because only one bit is accepted per cycle.

Reset
- REQ-021: `rst`=1 at a rising edge SHALL force the following, taking priority over `din_valid`:
  - both lanes to IDLE and both counters to 0;
  - `word0` and `word1` to 0;
  - `word0_valid`, `word1_valid` and `err` to 0.
- REQ-022: Reset mid-word SHALL discard partial bits; the first accepted bit after reset is bit 0.

Configuration
- REQ-023: Macro `SERIAL_DEMUX_DESER_PARITY_EN`, defined: each lane word is WIDTH data bits followed by one even-parity bit.
  - On the parity-bit edge, `wordN` SHALL update and `wordN_valid` SHALL pulse next cycle.
  - `err` SHALL pulse in that same cycle if the XOR of data and parity bits is 1.
- REQ-024: Macro undefined: no PAR state exists, words complete after WIDTH bits, and `err` SHALL be tied to 0.

Structure
- REQ-025: Package `serial_demux_deser_pkg` SHALL hold:
  - the lane-state enumeration type (IDLE, SHIFT, PAR);
  - the lane-index constants LANE0=0 and LANE1=1;
  - the default-width constant 4.
- REQ-026: Sub-module `demux_deser_lane` (FSM, counter, shift register, output register, parity check) SHALL be instantiated twice.
  - The top level only decodes `sel` into per-lane bit enables and wires the outputs.

Verification (WIDTH=4)
- REQ-027: Reset, then send bits 1,0,1,1 with `sel`=0 → `word0`=4'b1101, `word0_valid` high for 1 cycle, `word1`=0.
- REQ-028: Interleave: lane-0 bits 0,0,0,1 and lane-1 bits 1,1,1,0, alternating `sel` each cycle → `word0`=4'h8 and `word1`=4'h7, with valid pulses in consecutive cycles.
- REQ-029: Send 2 bits, idle 5 cycles with `din_valid`=0, then 2 more bits (sequence 1,1,0,0) → `word0`=4'h3, with no early valid pulse.
- REQ-030: Send 3 bits to lane 1, assert `rst` for 1 cycle, then send 0,1,0,1 → `word1`=4'hA.
- REQ-031 (PARITY_EN): Send data 1,0,1,1 then parity 1 → `word0`=4'hD, valid pulse, `err`=0. Send the same data with parity 0 → `err` pulses together with the valid pulse.
- REQ-032 (no PARITY_EN): Send 8 consecutive lane-0 bits → two `word0_valid` pulses four cycles apart, and `err` stays 0.
